// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  // All divide/remainder encodings have funct3[2] set
  function automatic logic is_div(input md_op_e o);
    return o[2];
  endfunction

  // rs1 is a signed view for everything except MULHU and the unsigned divides
  function automatic logic a_is_signed(input md_op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_MULHSU) ||
           (o == OP_DIV) || (o == OP_REM);
  endfunction

  // rs2 is a signed view only for MUL, MULH and the signed divides
  function automatic logic b_is_signed(input md_op_e o);
    return (o == OP_MUL) || (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic            dividend_bit,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // rem_in < divisor always holds, so the top bit of diff is a clean borrow flag
  always_comb begin
    trial   = {rem_in, dividend_bit};
    diff    = trial - {1'b0, divisor};
    q_bit   = ~diff[XLEN];
    rem_out = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on operand magnitudes,
// sign fix-up on completion, valid/ready on both sides and a flush kill.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] ITERS = CW'(XLEN);
  localparam logic [CW-1:0] LAST  = CW'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_reg, state_next;
  md_op_e            op_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [CW-1:0]     count_reg;
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opnd_reg;
  logic              neg_reg;
  logic              rem_neg_reg;
  logic [XLEN-1:0]   result_reg;

  // request decode
  md_op_e            op_in;
  logic              accept;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result;

  // iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_next;
  logic [XLEN-1:0]   step_rem;
  logic              step_q;
  logic [2*XLEN-1:0] div_acc_next;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fin_result;

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign out_tag   = tag_reg;
  assign accept    = in_valid && in_ready && !kill;

  // Decode the incoming request: magnitudes, sign views and the no-iteration cases
  always_comb begin
    op_in    = md_op_e'(op);
    a_neg    = a_is_signed(op_in) && a[XLEN-1];
    b_neg    = b_is_signed(op_in) && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div(op_in) && (b == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (a == MOST_NEG) && (b == '1);
    special  = div_zero || div_ovf;
    special_result = '0;
    if (div_zero) begin
      // remainder ops hand back the dividend, quotient ops saturate to all ones
      special_result = op_in[1] ? a : '1;
    end else if (div_ovf) begin
      special_result = op_in[1] ? '0 : a;
    end
  end

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in       (acc_reg[2*XLEN-1:XLEN]),
    .divisor      (opnd_reg),
    .dividend_bit (acc_reg[XLEN-1]),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // Next accumulator for either iteration, plus the sign-fixed result of the final step
  always_comb begin
    // multiply: {hi, lo} with the multiplier in lo, add-then-shift-right
    mul_sum      = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                   (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
    mul_acc_next = {mul_sum, acc_reg[XLEN-1:1]};
    // divide: {remainder, dividend/quotient}, quotient bits shift in at the bottom
    div_acc_next = {step_rem, acc_reg[XLEN-2:0], step_q};
    acc_step     = (state_reg == MUL) ? mul_acc_next : div_acc_next;

    prod    = neg_reg ? -acc_step : acc_step;
    quo_fix = neg_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix = rem_neg_reg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    if (state_reg == MUL) begin
      fin_result = (op_reg == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      fin_result = op_reg[1] ? rem_fix : quo_fix;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: iterate until the last bit, hold DONE until consumed; kill wins
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && !kill) begin
          if (special) begin
            state_next = DONE;
          end else if (is_div(op_in)) begin
            state_next = DIV;
          end else begin
            state_next = MUL;
          end
        end
      end
      MUL, DIV: begin
        if (count_reg == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (kill) begin
      state_next = IDLE;
    end
  end

  // Operand capture, per-cycle iteration and result registration
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg      <= OP_MUL;
      tag_reg     <= '0;
      count_reg   <= '0;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      neg_reg     <= 1'b0;
      rem_neg_reg <= 1'b0;
      result_reg  <= '0;
    end else if (accept) begin
      op_reg      <= op_in;
      tag_reg     <= in_tag;
      count_reg   <= ITERS;
      neg_reg     <= a_neg ^ b_neg;
      rem_neg_reg <= a_neg;
      if (is_div(op_in)) begin
        opnd_reg <= b_mag;
        acc_reg  <= {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd_reg <= a_mag;
        acc_reg  <= {{XLEN{1'b0}}, b_mag};
      end
      if (special) begin
        result_reg <= special_result;
      end
    end else if (!kill && ((state_reg == MUL) || (state_reg == DIV))) begin
      count_reg <= count_reg - LAST;
      acc_reg   <= acc_step;
      if (count_reg == LAST) begin
        result_reg <= fin_result;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected results,
// a monitor pops and compares on every output handshake.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [XLEN-1:0]  a, b;
  logic [TAG_W-1:0] in_tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN+TAG_W-1:0] exp_q[$];

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected entry
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got result 0x%08h tag %0d, expected none", result, out_tag);
      end else begin
        logic [XLEN+TAG_W-1:0] e;
        e = exp_q.pop_front();
        $display("txn: tag %0d result 0x%08h (expected tag %0d result 0x%08h)",
                 out_tag, result, e[TAG_W-1:0], e[XLEN+TAG_W-1:TAG_W]);
        check("result", result, e[XLEN+TAG_W-1:TAG_W]);
        check("out_tag", 32'(out_tag), 32'(e[TAG_W-1:0]));
      end
    end
  end

  // Issue one op, check latency, optionally stall the output for bp cycles
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input logic [31:0] exp, input int lat, input int bp);
    int cyc;
    @(negedge clk);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_tag = t; in_valid = 1'b1;
    out_ready = (bp == 0);
    exp_q.push_back({exp, t});
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    for (int i = 0; i < bp; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_result", result, exp);
      check("bp_out_tag", 32'(out_tag), 32'(t));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    if (bp > 0) check("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  // No output may appear for n cycles
  task automatic expect_quiet(input string name, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; in_tag = '0;
    kill = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);

    // multiplies
    issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 33, 0);
    issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd4, 32'h4000_0000, 33, 0);
    issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 33, 0);
    issue(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 33, 0);
    // divides, DIVU with 5 cycles of backpressure
    issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd7, 32'hFFFF_FFFD, 33, 0);
    issue(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd8, 32'hFFFF_FFFF, 33, 0);
    issue(OP_DIVU,   32'd100,        32'd7,         5'd9, 32'd14,        33, 5);
    issue(OP_REMU,   32'd100,        32'd7,         5'd10, 32'd2,        33, 0);
    // special cases
    issue(OP_DIV,    32'd5,          32'd0,         5'd11, 32'hFFFF_FFFF, 1, 0);
    issue(OP_REM,    32'd5,          32'd0,         5'd12, 32'd5,         1, 0);
    issue(OP_DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1, 0);
    issue(OP_REMU,   32'd5,          32'd0,         5'd16, 32'd5,         1, 0);
    issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 0);
    issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         1, 0);

    // kill at iteration 10 of a DIVU
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_tag = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_in_ready", 32'(in_ready), 32'd1);
    check("kill_busy", 32'(busy), 32'd0);
    expect_quiet("kill_no_output", 40);

    // synchronous reset in the middle of a MUL
    @(negedge clk);
    op = OP_MUL; a = 32'd12; b = 32'd13; in_tag = 5'd21; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_out_tag", 32'(out_tag), 32'd0);
    expect_quiet("midrst_no_output", 40);

    // kill together with a request in IDLE: request is dropped
    @(negedge clk);
    op = OP_MULHU; a = 32'd3; b = 32'd4; in_tag = 5'd22; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("killreq_busy", 32'(busy), 32'd0);
    check("killreq_in_ready", 32'(in_ready), 32'd1);
    expect_quiet("killreq_no_output", 40);

    // unit still works afterwards
    issue(OP_DIVU, 32'd100, 32'd7, 5'd31, 32'd14, 33, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised RV32M-style multiply/divide unit for the pipelined RVxxIMC core.
- Sits beside the combinational ALU in the execute stage.
- Accepts one operation over a valid/ready handshake, iterates one bit per cycle, and returns a tagged result over a valid/ready handshake.
- Supports a kill for pipeline flushes.

Parameters:
- XLEN, 32: operand and result width; must be at least 8 and a power of two.
- TAG_W, 5: width of the opaque tag carried from input to output (destination register index).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  tag captured with the operation.
- kill  in  1  abort the in-flight or completed operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, rst.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, out_tag=0, state=IDLE, counter=0.
  - rst overrides everything, including mid-operation: the operation is discarded with no output.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept: on a cycle where in_valid && in_ready && !kill, latch op, a, b and in_tag.
  - Div-by-zero or signed-overflow special case -> DONE.
  - op<4 -> MUL.
  - Otherwise -> DIV.
  - Counter loads XLEN.
- MUL: shift-add on operand magnitudes, 2*XLEN-bit accumulator, one bit per cycle.
  - Signedness: MUL and MULH treat a and b as signed; MULHSU treats a as signed, b as unsigned; MULHU treats both as unsigned.
  - Final product is negated when the operand signs differ (signed views only).
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- DIV: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a). Signed ops only.
- Counter decrements each iteration cycle. When it reaches 0, the sign-fixed result is registered into result and the FSM enters DONE.
- Latency: out_valid rises exactly XLEN+1 cycles after the accept edge (33 for XLEN=32). Special cases take 1 cycle.
- Special cases (no iteration):
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a = most negative, b = all ones): DIV -> a; REM -> 0.
- DONE: out_valid=1. result and out_tag stay stable until out_valid && out_ready, then the FSM returns to IDLE.
  - The next operation can be accepted the following cycle; no same-cycle turnaround.
- kill: in any state, the next state is IDLE and out_valid drops next cycle. The result is never presented.
  - kill in the same cycle as in_valid in IDLE: request not accepted.
  - kill in the same cycle as the out handshake in DONE: the handshake completes (consumer already sampled), then the FSM goes to IDLE.
- Width rules: the accumulator is 2*XLEN bits wide. Negation is two's complement in the accumulator width. The counter width is $clog2(XLEN+1).

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic [2:0] md_op_e with the funct3 values above.
  - typedef enum logic [1:0] md_state_e for IDLE/MUL/DIV/DONE.
  - Helper function is_div(md_op_e).
- One natural sub-module, muldiv_div_step: combinational restoring step taking partial remainder, divisor and next dividend bit, and returning the new remainder and quotient bit. It is reusable by a future radix-4 variant.

Test Plan:
- Sign handling and latency: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid exactly 33 cycles after accept, out_tag equals in_tag.
- High multiply: MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Division: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - All return out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, result and out_tag stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, new op accepted on the following cycle.
- Abort: kill at iteration 10 of DIVU -> no out_valid ever, in_ready=1 next cycle. Repeat with rst mid-op -> all outputs at reset values. kill together with in_valid in IDLE -> not accepted, busy stays 0.
